// File: rtl/modexp_engine.sv
// Modular exponentiation engine: RESULT = M^E mod N by left-to-right square-and-multiply
// on top of a bit-serial interleaved (shift-add) modular multiplier.
module modexp_engine #(
  parameter int BITS = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            LOAD,
  input  logic            GO,
  input  logic [BITS-1:0] M,
  input  logic [BITS-1:0] E,
  input  logic [BITS-1:0] N,
  output logic [BITS-1:0] RESULT,
  output logic            DONE,
  output logic            BUSY,
  output logic            ERR
);

  localparam int PW = BITS + 2;
  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [IW-1:0] TOP_BIT = IW'(BITS - 1);

  // The exponent-bit decision (NEXT) is folded into the last multiply cycle,
  // so it has no state encoding of its own.
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SQR,
    MUL,
    FIN,
    HOLD
  } state_t;

  state_t          state;
  logic [BITS-1:0] mr, er, nr;
  logic [BITS-1:0] a;
  logic [PW-1:0]   p;
  logic [IW-1:0]   i, j;
  logic            mload;

  logic [PW-1:0]   addend;
  logic [PW-1:0]   t;
  logic [PW-1:0]   red;

  // Bring T (< 3*Nr) back below Nr with at most one of two conditional subtractions.
  function automatic logic [PW-1:0] mod_reduce(input logic [PW-1:0] tv,
                                               input logic [BITS-1:0] n);
    logic [PW-1:0] n1, n2;
    n1 = {2'b00, n};
    n2 = {1'b0, n, 1'b0};
    if (tv >= n2)
      mod_reduce = tv - n2;
    else if (tv >= n1)
      mod_reduce = tv - n1;
    else
      mod_reduce = tv;
  endfunction

  // Multiplier datapath: X is always A, Y is A when squaring and Mr when multiplying.
  always_comb begin
    addend = '0;
    if (a[j])
      addend = (state == MUL) ? {2'b00, mr} : {2'b00, a};
    t   = p + p + addend;
    red = mod_reduce(t, nr);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      mr     <= '0;
      er     <= '0;
      nr     <= '0;
      a      <= '0;
      p      <= '0;
      i      <= '0;
      j      <= '0;
      mload  <= 1'b0;
      RESULT <= '0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            mr <= M;
            er <= E;
            nr <= N;
          end else if (GO) begin
            state <= INIT;
          end
        end

        INIT: begin
          BUSY <= 1'b1;
          if (nr == '0 || mr >= nr) begin
            ERR    <= 1'b1;
            RESULT <= '0;
            a      <= '0;
            state  <= FIN;
          end else begin
            ERR   <= 1'b0;
            a     <= (nr == BITS'(1)) ? '0 : BITS'(1);
            i     <= TOP_BIT;
            mload <= 1'b1;
            state <= SQR;
          end
        end

        SQR, MUL: begin
          if (mload) begin
            p     <= '0;
            j     <= TOP_BIT;
            mload <= 1'b0;
          end else if (j != '0) begin
            p <= red;
            j <= j - 1'b1;
          end else begin
            // Last multiplier cycle: commit the product and pick the next step.
            a     <= red[BITS-1:0];
            p     <= '0;
            mload <= 1'b1;
            if (state == SQR && er[i]) begin
              state <= MUL;
            end else if (i == '0) begin
              mload <= 1'b0;
              state <= FIN;
            end else begin
              i     <= i - 1'b1;
              state <= SQR;
            end
          end
        end

        FIN: begin
          RESULT <= a;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
          state  <= HOLD;
        end

        HOLD: begin
          if (LOAD) begin
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            mr    <= M;
            er    <= E;
            nr    <= N;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_engine.sv
// Scoreboard bench for modexp_engine: a 16-bit and a 64-bit instance, directed vectors.
`timescale 1ns/1ps
module tb_modexp_engine;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET;

  logic        load16, go16;
  logic [15:0] m16, e16, n16, res16;
  logic        done16, busy16, err16;

  logic        load64, go64;
  logic [63:0] m64, e64, n64, res64;
  logic        done64, busy64, err64;

  modexp_engine #(.BITS(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .LOAD(load16), .GO(go16),
    .M(m16), .E(e16), .N(n16),
    .RESULT(res16), .DONE(done16), .BUSY(busy16), .ERR(err16)
  );

  modexp_engine #(.BITS(64)) dut64 (
    .CLK(CLK), .RESET(RESET), .LOAD(load64), .GO(go64),
    .M(m64), .E(e64), .N(n64),
    .RESULT(res64), .DONE(done64), .BUSY(busy64), .ERR(err64)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          lat;
    int          go_edge;
  } exp_t;

  exp_t q16[$];
  exp_t q64[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitors: pop and compare on each DONE rising edge.
  initial begin
    logic pd;
    exp_t x;
    pd = 1'b0;
    forever begin
      @(negedge CLK);
      if (done16 && !pd) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done16_unexpected: got DONE with result %0d, required no DONE", res16);
        end else begin
          x = q16.pop_front();
          check("result16", {48'd0, res16}, x.res);
          check("err16", {63'd0, err16}, {63'd0, x.err});
          check("latency16", 64'(cyc - x.go_edge), 64'(x.lat));
        end
      end
      pd = done16;
    end
  end

  initial begin
    logic pd;
    exp_t x;
    pd = 1'b0;
    forever begin
      @(negedge CLK);
      if (done64 && !pd) begin
        if (q64.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done64_unexpected: got DONE with result %0d, required no DONE", res64);
        end else begin
          x = q64.pop_front();
          check("result64", res64, x.res);
          check("err64", {63'd0, err64}, {63'd0, x.err});
          check("latency64", 64'(cyc - x.go_edge), 64'(x.lat));
        end
      end
      pd = done64;
    end
  end

  task automatic load16_t(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n);
    @(negedge CLK);
    load16 = 1'b1; m16 = m; e16 = e; n16 = n;
    @(negedge CLK);
    load16 = 1'b0;
  endtask

  task automatic go16_t(output int ge);
    go16 = 1'b1;
    ge = cyc + 1;
    @(negedge CLK);
    go16 = 1'b0;
  endtask

  task automatic push16(input logic [63:0] r, input logic er, input int lat, input int ge);
    exp_t x;
    x.res = r; x.err = er; x.lat = lat; x.go_edge = ge;
    q16.push_back(x);
  endtask

  task automatic wait16(input int maxc);
    int k = 0;
    while (!done16 && k < maxc) begin
      @(negedge CLK);
      k++;
    end
    if (!done16) begin
      checks++;
      errors++;
      $display("FAIL timeout16: DONE still 0 after %0d cycles, required 1", maxc);
    end
  endtask

  int ge;

  initial begin
    RESET = 1'b1;
    load16 = 0; go16 = 0; m16 = 0; e16 = 0; n16 = 0;
    load64 = 0; go64 = 0; m64 = 0; e64 = 0; n64 = 0;
    repeat (3) @(negedge CLK);
    check("rst_result16", {48'd0, res16}, 64'd0);
    check("rst_done16", {63'd0, done16}, 64'd0);
    check("rst_busy16", {63'd0, busy16}, 64'd0);
    check("rst_err16", {63'd0, err16}, 64'd0);
    check("rst_result64", res64, 64'd0);
    check("rst_done64", {63'd0, done64}, 64'd0);
    RESET = 1'b0;

    // 190^3 mod 1189 = 848, DONE at edge 2+18*17 = 308
    load16_t(16'd190, 16'd3, 16'd1189);
    go16_t(ge);
    push16(64'd848, 1'b0, 308, ge);
    check("busy_edge0", {63'd0, busy16}, 64'd0);
    @(negedge CLK);
    check("busy_edge1", {63'd0, busy16}, 64'd1);
    while (cyc < ge + 307) @(negedge CLK);
    check("busy_edge307", {63'd0, busy16}, 64'd1);
    check("done_edge307", {63'd0, done16}, 64'd0);
    wait16(20);
    check("busy_after_done", {63'd0, busy16}, 64'd0);

    // Ack + new operands; 848^187 mod 1189 = 190, popcount(187)=6 -> 2+22*17 = 376
    load16_t(16'd848, 16'd187, 16'd1189);
    check("ack_done16", {63'd0, done16}, 64'd0);
    go16 = 1'b1;
    ge = cyc + 1;
    push16(64'd190, 1'b0, 376, ge);
    @(negedge CLK);
    wait16(500);
    repeat (20) @(negedge CLK);
    check("no_restart_done", {63'd0, done16}, 64'd1);
    check("no_restart_busy", {63'd0, busy16}, 64'd0);
    check("no_restart_result", {48'd0, res16}, 64'd190);
    go16 = 1'b0;
    load16_t(16'd5, 16'd0, 16'd1189);
    check("ack2_done16", {63'd0, done16}, 64'd0);

    // E=0 -> 1, 2+16*17 = 274
    go16_t(ge);
    push16(64'd1, 1'b0, 274, ge);
    wait16(400);
    load16_t(16'd1200, 16'd3, 16'd1189);
    // M >= N -> error path, DONE at edge 2
    go16_t(ge);
    push16(64'd0, 1'b1, 2, ge);
    wait16(10);
    check("err_flag16", {63'd0, err16}, 64'd1);
    load16_t(16'd190, 16'd3, 16'd1189);
    check("err_cleared16", {63'd0, err16}, 64'd0);

    // Mid-run LOAD is ignored
    go16_t(ge);
    push16(64'd848, 1'b0, 308, ge);
    repeat (50) @(negedge CLK);
    load16_t(16'd5, 16'd0, 16'd7);
    wait16(400);
    load16_t(16'd190, 16'd3, 16'd1189);

    // RESET at edge 100 of a run
    go16_t(ge);
    while (cyc < ge + 99) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_result", {48'd0, res16}, 64'd0);
    check("midrst_done", {63'd0, done16}, 64'd0);
    check("midrst_busy", {63'd0, busy16}, 64'd0);
    check("midrst_err", {63'd0, err16}, 64'd0);
    RESET = 1'b0;
    load16_t(16'd190, 16'd3, 16'd1189);
    go16_t(ge);
    push16(64'd848, 1'b0, 308, ge);
    wait16(400);
    load16_t(16'd5, 16'd3, 16'd1189);

    // LOAD and GO together in IDLE: capture 7,2 but no start; then GO -> 49, 2+17*17 = 291
    @(negedge CLK);
    load16 = 1'b1; go16 = 1'b1; m16 = 16'd7; e16 = 16'd2; n16 = 16'd1189;
    @(negedge CLK);
    load16 = 1'b0; go16 = 1'b0;
    repeat (5) @(negedge CLK);
    check("loadgo_no_busy", {63'd0, busy16}, 64'd0);
    check("loadgo_no_done", {63'd0, done16}, 64'd0);
    go16_t(ge);
    push16(64'd49, 1'b0, 291, ge);
    wait16(400);

    // 64-bit: 190^5 mod 288230439905132863 = 247609900000, DONE at edge 4292
    @(negedge CLK);
    load64 = 1'b1; m64 = 64'd190; e64 = 64'd5; n64 = 64'd288230439905132863;
    @(negedge CLK);
    load64 = 1'b0;
    go64 = 1'b1;
    ge = cyc + 1;
    begin
      exp_t x;
      x.res = 64'd247609900000; x.err = 1'b0; x.lat = 4292; x.go_edge = ge;
      q64.push_back(x);
    end
    @(negedge CLK);
    go64 = 1'b0;
    begin
      int k = 0;
      while (!done64 && k < 5000) begin
        @(negedge CLK);
        k++;
      end
      if (!done64) begin
        checks++;
        errors++;
        $display("FAIL timeout64: DONE still 0 after %0d cycles, required 1", k);
      end
    end
    repeat (2) @(negedge CLK);
    check("pending16", 64'(q16.size()), 64'd0);
    check("pending64", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
